// File: rtl/multi_digit_down_counter.sv
// Cascade of BCD down-counter digits with per-digit modulus and borrow ripple.
// Optional wrap-at-zero behaviour is enabled by defining MULTI_DIGIT_DOWN_COUNTER_WRAP_EN.
module multi_digit_down_counter #(
    parameter int unsigned         DIGITS  = 4,
    parameter logic [4*DIGITS-1:0] MOD_VEC = 16'hAA6A
) (
    input  logic                clock,
    input  logic                clr,
    input  logic                loadn,
    input  logic                en,
    input  logic [4*DIGITS-1:0] data,
    output logic [4*DIGITS-1:0] Dout,
    output logic                zero,
    output logic                tc,
    output logic                done
);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic [4*DIGITS-1:0] dec_val, load_val;
    logic                zero_q, zero_d;
    logic                done_q, done_d;
    logic [DIGITS:0]     borrow;
    logic                count_is_zero;

    assign count_is_zero = (count_q == '0);

    // borrow[i] is set when every digit below i is zero, so digit i steps this cycle
    always_comb begin
        borrow    = '0;
        borrow[0] = 1'b1;
        dec_val   = '0;
        load_val  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            borrow[i+1] = borrow[i] & (count_q[4*i +: 4] == 4'd0);
            if (borrow[i]) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = MOD_VEC[4*i +: 4] - 4'd1;
                end else begin
                    dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                end
            end else begin
                dec_val[4*i +: 4] = count_q[4*i +: 4];
            end
            if (data[4*i +: 4] >= MOD_VEC[4*i +: 4]) begin
                load_val[4*i +: 4] = MOD_VEC[4*i +: 4] - 4'd1;
            end else begin
                load_val[4*i +: 4] = data[4*i +: 4];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        if (!loadn) begin
            count_d = load_val;
            zero_d  = (load_val == '0);
        end else if (en) begin
            if (!count_is_zero) begin
                count_d = dec_val;
                zero_d  = (dec_val == '0);
                done_d  = (dec_val == '0);
            end else begin
`ifdef MULTI_DIGIT_DOWN_COUNTER_WRAP_EN
                // From zero every digit borrows, so dec_val is the all-maximum value
                count_d = dec_val;
                zero_d  = 1'b0;
`else
                count_d = count_q;
                zero_d  = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            count_q <= '0;
            zero_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign Dout = count_q;
    assign zero = zero_q;
    assign done = done_q;
    assign tc   = en & count_is_zero;

endmodule

// File: tb/tb_multi_digit_down_counter.sv
// Scoreboard bench for multi_digit_down_counter: stimulus pushes expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multi_digit_down_counter;

    logic        clock = 1'b0;
    logic        clr   = 1'b1;
    logic        loadn = 1'b1;
    logic        en    = 1'b0;
    logic [15:0] data  = '0;
    logic [15:0] Dout;
    logic        zero, tc, done;

    typedef struct {
        bit          is_tc;
        logic [15:0] dout;
        logic        zero;
        logic        done;
        logic        tc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    multi_digit_down_counter dut (
        .clock (clock),
        .clr   (clr),
        .loadn (loadn),
        .en    (en),
        .data  (data),
        .Dout  (Dout),
        .zero  (zero),
        .tc    (tc),
        .done  (done)
    );

    always #5 clock = ~clock;

    // Monitor: compare everything queued since the previous negedge
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (e.is_tc) begin
                if (tc !== e.tc) begin
                    errors++;
                    $display("FAIL %s: tc got %b expected %b", e.name, tc, e.tc);
                end
            end else if (Dout !== e.dout || zero !== e.zero || done !== e.done) begin
                errors++;
                $display("FAIL %s: Dout/zero/done got %h/%b/%b expected %h/%b/%b",
                         e.name, Dout, zero, done, e.dout, e.zero, e.done);
            end
        end
    end

    // Apply inputs for one edge, then queue the state expected after that edge
    task automatic cycle(input logic c, input logic ln, input logic e_in, input logic [15:0] d,
                         input logic [15:0] x_dout, input logic x_zero, input logic x_done,
                         input string name);
        exp_t e;
        clr   = c;
        loadn = ln;
        en    = e_in;
        data  = d;
        @(posedge clock);
        #1;
        e.is_tc = 1'b0;
        e.dout  = x_dout;
        e.zero  = x_zero;
        e.done  = x_done;
        e.tc    = 1'b0;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    // Change en between edges and check tc before the next edge
    task automatic chk_tc(input logic e_in, input logic x_tc, input string name);
        exp_t e;
        clr   = 1'b0;
        loadn = 1'b1;
        en    = e_in;
        #1;
        e.is_tc = 1'b1;
        e.dout  = '0;
        e.zero  = 1'b0;
        e.done  = 1'b0;
        e.tc    = x_tc;
        e.name  = name;
        exp_q.push_back(e);
        @(negedge clock);
        #1;
    endtask

    initial begin
        // Reset with en high, held for two edges
        cycle(1, 1, 1, 16'h1234, 16'h0000, 1, 0, "reset");
        cycle(1, 0, 1, 16'h4321, 16'h0000, 1, 0, "reset_hold");

        // Load and borrow ripple
        cycle(0, 0, 0, 16'h0100, 16'h0100, 0, 0, "load_0100");
        cycle(0, 1, 1, 16'h0000, 16'h0059, 0, 0, "borrow_0059");
        cycle(0, 0, 0, 16'h1000, 16'h1000, 0, 0, "load_1000");
        cycle(0, 1, 1, 16'h0000, 16'h0959, 0, 0, "borrow_0959");

        // Clamping
        cycle(0, 0, 0, 16'hFFFF, 16'h9959, 0, 0, "clamp_ffff");
        cycle(0, 0, 0, 16'h0A0A, 16'h0909, 0, 0, "clamp_0a0a");
        cycle(0, 0, 0, 16'h0070, 16'h0050, 0, 0, "clamp_mod6");
        cycle(0, 0, 0, 16'h0000, 16'h0000, 1, 0, "load_zero");

        // Expiry
        cycle(0, 0, 0, 16'h0002, 16'h0002, 0, 0, "load_0002");
        cycle(0, 1, 1, 16'h0000, 16'h0001, 0, 0, "step_0001");
        cycle(0, 1, 1, 16'h0000, 16'h0000, 1, 1, "expire");
`ifdef MULTI_DIGIT_DOWN_COUNTER_WRAP_EN
        cycle(0, 1, 1, 16'h0000, 16'h9959, 0, 0, "wrap_9959");
        cycle(0, 1, 1, 16'h0000, 16'h9958, 0, 0, "wrap_9958");
`else
        cycle(0, 1, 1, 16'h0000, 16'h0000, 1, 0, "hold_zero_1");
        cycle(0, 1, 1, 16'h0000, 16'h0000, 1, 0, "hold_zero_2");
`endif

        // done drops on a plain hold
        cycle(0, 0, 0, 16'h0001, 16'h0001, 0, 0, "load_0001");
        cycle(0, 1, 1, 16'h0000, 16'h0000, 1, 1, "expire_2");
        cycle(0, 1, 0, 16'h0000, 16'h0000, 1, 0, "done_drop");

        // Priority
        cycle(0, 0, 1, 16'h0030, 16'h0030, 0, 0, "load_beats_en");
        cycle(0, 1, 1, 16'h0000, 16'h0029, 0, 0, "step_0029");
        cycle(0, 1, 0, 16'h0000, 16'h0029, 0, 0, "hold_0029");
        cycle(0, 0, 0, 16'h0025, 16'h0025, 0, 0, "load_0025");
        cycle(0, 1, 1, 16'h0000, 16'h0024, 0, 0, "step_0024");
        cycle(1, 0, 1, 16'h0099, 16'h0000, 1, 0, "clr_mid_count");

        // Terminal count
        chk_tc(1, 1, "tc_zero_en1");
        chk_tc(0, 0, "tc_zero_en0");
        chk_tc(1, 1, "tc_zero_en1_again");
        cycle(0, 0, 0, 16'h0005, 16'h0005, 0, 0, "load_0005");
        chk_tc(1, 0, "tc_nonzero");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending %0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
